// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: fetches up to two PTEs over a single-outstanding read port and writes valid leaves into the TLB.
// Optional: define ARMLEOCPU_PTW_AD_CHECK_EN to fault on leaves whose Accessed bit is clear.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for walk_req
// FETCH    | PTE read in flight (mem_req high) or about to be issued (mem_req low)
// COMPLETE | one cycle: leaf written to TLB, walk_done pulses
// FAULT    | one cycle: walk_done pulses with exactly one fault flag
module armleocpu_ptw #(
  parameter int MEM_ADDR_W = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  walk_req,
  input  logic [19:0]           walk_virtual_address,
  input  logic [21:0]           satp_ppn,
  output logic                  walk_busy,
  output logic                  walk_done,
  output logic                  walk_pagefault,
  output logic                  walk_accessfault,
  output logic [21:0]           walk_phys,
  output logic [7:0]            walk_accesstag,

  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_err,

  output logic [1:0]            tlb_command,
  output logic [19:0]           tlb_virtual_address_w,
  output logic [7:0]            tlb_accesstag_w,
  output logic [21:0]           tlb_phys_w
);

  localparam logic [1:0] TLB_CMD_NONE  = 2'b00;
  localparam logic [1:0] TLB_CMD_WRITE = 2'b10;

`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
  localparam bit AD_CHECK = 1'b1;
`else
  localparam bit AD_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_COMPLETE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PTE_ACCESS_FAULT,
    PTE_PAGE_FAULT,
    PTE_LEAF,
    PTE_POINTER
  } pte_kind_t;

  state_t      state;
  logic        level;
  logic [19:0] va_r;
  logic [21:0] satp_r;
  logic [21:0] ptr_ppn;
  pte_kind_t   pte_kind;
  logic [21:0] leaf_phys;

  // RSW bits are software-reserved and never affect the walk
  logic unused_rsw;
  assign unused_rsw = &{1'b0, mem_rdata[9:8]};

  function automatic logic [MEM_ADDR_W-1:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
    return MEM_ADDR_W'({ppn, 12'b0}) + MEM_ADDR_W'({idx, 2'b00});
  endfunction

  always_comb begin
    pte_kind = PTE_PAGE_FAULT;
    if (mem_err) begin
      pte_kind = PTE_ACCESS_FAULT;
    end else if (!mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2])) begin
      pte_kind = PTE_PAGE_FAULT;
    end else if (mem_rdata[1] || mem_rdata[3]) begin
      if (level && (mem_rdata[19:10] != 10'd0))
        pte_kind = PTE_PAGE_FAULT;
      else if (AD_CHECK && !mem_rdata[6])
        pte_kind = PTE_PAGE_FAULT;
      else
        pte_kind = PTE_LEAF;
    end else if (level) begin
      pte_kind = PTE_POINTER;
    end
  end

  // megapage leaves take their low PPN bits from VPN0
  assign leaf_phys = level ? {mem_rdata[31:20], va_r[9:0]} : mem_rdata[31:10];

  assign walk_busy             = (state != S_IDLE);
  assign tlb_virtual_address_w = va_r;
  assign tlb_phys_w            = walk_phys;
  assign tlb_accesstag_w       = walk_accesstag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      level            <= 1'b1;
      va_r             <= '0;
      satp_r           <= '0;
      ptr_ppn          <= '0;
      mem_req          <= 1'b0;
      mem_addr         <= '0;
      walk_done        <= 1'b0;
      walk_pagefault   <= 1'b0;
      walk_accessfault <= 1'b0;
      walk_phys        <= '0;
      walk_accesstag   <= '0;
      tlb_command      <= TLB_CMD_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (walk_req) begin
            va_r     <= walk_virtual_address;
            satp_r   <= satp_ppn;
            level    <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= pte_addr(satp_ppn, walk_virtual_address[19:10]);
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= level ? pte_addr(satp_r, va_r[19:10]) : pte_addr(ptr_ppn, va_r[9:0]);
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            case (pte_kind)
              PTE_ACCESS_FAULT: begin
                walk_done        <= 1'b1;
                walk_accessfault <= 1'b1;
                state            <= S_FAULT;
              end
              PTE_PAGE_FAULT: begin
                walk_done      <= 1'b1;
                walk_pagefault <= 1'b1;
                state          <= S_FAULT;
              end
              PTE_LEAF: begin
                walk_done      <= 1'b1;
                walk_phys      <= leaf_phys;
                walk_accesstag <= mem_rdata[7:0];
                tlb_command    <= TLB_CMD_WRITE;
                state          <= S_COMPLETE;
              end
              default: begin
                ptr_ppn <= mem_rdata[31:10];
                level   <= 1'b0;
              end
            endcase
          end
        end
        S_COMPLETE, S_FAULT: begin
          walk_done        <= 1'b0;
          walk_pagefault   <= 1'b0;
          walk_accessfault <= 1'b0;
          tlb_command      <= TLB_CMD_NONE;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Self-checking bench for armleocpu_ptw: scripted PTE replies, expected walk results queued at issue and compared at walk_done.
module tb_armleocpu_ptw;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        walk_req = 1'b0;
  logic [19:0] walk_virtual_address = '0;
  logic [21:0] satp_ppn = '0;
  logic        walk_busy, walk_done, walk_pagefault, walk_accessfault;
  logic [21:0] walk_phys;
  logic [7:0]  walk_accesstag;
  logic        mem_req;
  logic [33:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic [1:0]  tlb_command;
  logic [19:0] tlb_virtual_address_w;
  logic [7:0]  tlb_accesstag_w;
  logic [21:0] tlb_phys_w;

  armleocpu_ptw #(.MEM_ADDR_W(34)) dut (
    .clk(clk), .rst_n(rst_n),
    .walk_req(walk_req), .walk_virtual_address(walk_virtual_address), .satp_ppn(satp_ppn),
    .walk_busy(walk_busy), .walk_done(walk_done), .walk_pagefault(walk_pagefault),
    .walk_accessfault(walk_accessfault), .walk_phys(walk_phys), .walk_accesstag(walk_accesstag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .tlb_command(tlb_command), .tlb_virtual_address_w(tlb_virtual_address_w),
    .tlb_accesstag_w(tlb_accesstag_w), .tlb_phys_w(tlb_phys_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pf;
    logic        af;
    logic        wr;
    logic [21:0] phys;
    logic [7:0]  tag;
    logic [19:0] va;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [21:0] last_phys = '0;
  logic [7:0]  last_tag = '0;
  int          req_rises = 0;
  int          wr_cnt = 0;
  logic        prev_req = 1'b0;

  // counts request starts and TLB write cycles, sampled just after each edge
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1 && prev_req !== 1'b1) req_rises++;
    prev_req = mem_req;
    if (tlb_command === CMD_WRITE) wr_cnt++;
  end

  function automatic logic [120:0] out_vec();
    return {walk_busy, walk_done, walk_pagefault, walk_accessfault, walk_phys, walk_accesstag,
            mem_req, mem_addr, tlb_command, tlb_virtual_address_w, tlb_accesstag_w, tlb_phys_w};
  endfunction

  function automatic exp_t make_exp(input logic pf, input logic af, input logic wr,
                                    input logic [21:0] phys, input logic [7:0] tag, input logic [19:0] va);
    exp_t e;
    e.pf = pf; e.af = af; e.wr = wr; e.va = va;
    e.phys = wr ? phys : last_phys;
    e.tag  = wr ? tag : last_tag;
    return e;
  endfunction

  // Issues one walk and answers n PTE reads; records addresses and handshake stability.
  task automatic drive_walk(input logic [21:0] satp, input logic [19:0] va, input int n,
                            input logic [31:0] d0, input logic [31:0] d1, input logic e1,
                            input int dly, input bit hold,
                            output logic [33:0] a0, output logic [33:0] a1,
                            output bit stable, output int wait0, output bit tmo);
    int w;
    logic [33:0] addr;
    @(negedge clk);
    satp_ppn = satp; walk_virtual_address = va; walk_req = 1'b1;
    @(negedge clk);
    if (!hold) walk_req = 1'b0;
    stable = 1'b1; tmo = 1'b0; a0 = '0; a1 = '0; wait0 = 0;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (mem_req !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        tmo = 1'b1;
        break;
      end
      addr = mem_addr;
      if (k == 0) begin
        wait0 = w;
        a0 = addr;
      end else begin
        a1 = addr;
      end
      repeat (dly) begin
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_addr !== addr) stable = 1'b0;
      end
      mem_ack = 1'b1;
      mem_rdata = (k == 0) ? d0 : d1;
      mem_err = (k == 0) ? 1'b0 : e1;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      if (mem_req !== 1'b0) stable = 1'b0;
    end
  endtask

  task automatic wait_done(output int lat, output bit tmo);
    lat = 0;
    while (walk_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tmo = (walk_done !== 1'b1);
  endtask

  task automatic test_reset();
    logic [120:0] obs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = out_vec();
    checks++;
    if (obs !== 121'd0) $display("FAIL reset_outputs: got %h expected 0", obs); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs = out_vec();
    checks++;
    if (obs !== 121'd0) $display("FAIL idle_after_reset: got %h expected 0", obs); else passes++;
  endtask

  task automatic test_two_level(input string nm, input int dly, input bit hold);
    logic [33:0] a0, a1;
    bit stable, tmo, tmo2;
    int wait0, lat, r0, w0;
    exp_t e, got;
    r0 = req_rises; w0 = wr_cnt;
    e = make_exp(1'b0, 1'b0, 1'b1, 22'h012345, 8'hCF, 20'h12345);
    exp_q.push_back(e);
    last_phys = e.phys; last_tag = e.tag;
    drive_walk(22'h00080, 20'h12345, 2, 32'h00020401, 32'h048D14CF, 1'b0, dly, hold, a0, a1, stable, wait0, tmo);
    wait_done(lat, tmo2);
    got = exp_q.pop_front();
    checks++;
    if ({a0, a1} !== {34'h80120, 34'h81D14})
      $display("FAIL %s addr: got %h/%h expected 80120/81d14", nm, a0, a1); else passes++;
    checks++;
    if ({tmo, tmo2, wait0, lat} !== {1'b0, 1'b0, 32'd0, 32'd0})
      $display("FAIL %s timing: got tmo=%0d/%0d start_wait=%0d done_lat=%0d expected 0/0/0/0", nm, tmo, tmo2, wait0, lat);
    else passes++;
    checks++;
    if (stable !== 1'b1) $display("FAIL %s handshake: got stable=%0d expected 1", nm, stable); else passes++;
    checks++;
    if ({walk_pagefault, walk_accessfault, tlb_command} !== {got.pf, got.af, CMD_WRITE})
      $display("FAIL %s status: got %b expected %b", nm, {walk_pagefault, walk_accessfault, tlb_command}, {got.pf, got.af, CMD_WRITE});
    else passes++;
    checks++;
    if ({walk_phys, walk_accesstag, tlb_virtual_address_w, tlb_phys_w, tlb_accesstag_w} !== {got.phys, got.tag, got.va, got.phys, got.tag})
      $display("FAIL %s data: got %h %h %h %h %h expected %h %h %h %h %h", nm, walk_phys, walk_accesstag,
               tlb_virtual_address_w, tlb_phys_w, tlb_accesstag_w, got.phys, got.tag, got.va, got.phys, got.tag);
    else passes++;
    if (hold) walk_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_rises - r0, wr_cnt - w0, walk_busy} !== {32'd2, 32'd1, 1'b0})
      $display("FAIL %s counts: got reqs=%0d writes=%0d busy=%0d expected 2/1/0", nm, req_rises - r0, wr_cnt - w0, walk_busy);
    else passes++;
  endtask

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        e1;
    logic [1:0]  n;
    logic        pf;
    logic        af;
    logic        wr;
    logic [21:0] phys;
    logic [7:0]  tag;
  } leaf_case_t;

  task automatic test_leaf_cases();
    leaf_case_t tbl[7];
    leaf_case_t c;
    logic [33:0] a0, a1, ea1;
    bit stable, tmo, tmo2;
    int wait0, lat, r0, w0;
    exp_t e, got;
    logic [1:0] ecmd;
    tbl[0] = '{32'h0010000F, 32'h00000000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 22'h000745, 8'h0F};
    tbl[1] = '{32'h0010040F, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0};
    tbl[2] = '{32'h00000000, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0};
    tbl[3] = '{32'h00000005, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0};
    tbl[4] = '{32'h00020401, 32'h048D14CF, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 22'h0, 8'h0};
    tbl[5] = '{32'h00020401, 32'h00000001, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0};
`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
    tbl[6] = '{32'h00020401, 32'h048D148F, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0};
`else
    tbl[6] = '{32'h00020401, 32'h048D148F, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 22'h012345, 8'h8F};
`endif
    for (int i = 0; i < 7; i++) begin
      c = tbl[i];
      r0 = req_rises; w0 = wr_cnt;
      e = make_exp(c.pf, c.af, c.wr, c.phys, c.tag, 20'h12345);
      exp_q.push_back(e);
      last_phys = e.phys; last_tag = e.tag;
      drive_walk(22'h00080, 20'h12345, int'(c.n), c.d0, c.d1, c.e1, 0, 1'b0, a0, a1, stable, wait0, tmo);
      wait_done(lat, tmo2);
      got = exp_q.pop_front();
      ea1 = (c.n == 2'd2) ? 34'h81D14 : 34'h0;
      ecmd = got.wr ? CMD_WRITE : CMD_NONE;
      checks++;
      if ({a0, a1} !== {34'h80120, ea1})
        $display("FAIL case%0d addr: got %h/%h expected 80120/%h", i, a0, a1, ea1); else passes++;
      checks++;
      if ({tmo, tmo2, lat, stable} !== {1'b0, 1'b0, 32'd0, 1'b1})
        $display("FAIL case%0d timing: got tmo=%0d/%0d lat=%0d stable=%0d expected 0/0/0/1", i, tmo, tmo2, lat, stable);
      else passes++;
      checks++;
      if ({walk_done, walk_pagefault, walk_accessfault, tlb_command} !== {1'b1, got.pf, got.af, ecmd})
        $display("FAIL case%0d status: got %b expected %b", i,
                 {walk_done, walk_pagefault, walk_accessfault, tlb_command}, {1'b1, got.pf, got.af, ecmd});
      else passes++;
      checks++;
      if ({walk_phys, walk_accesstag} !== {got.phys, got.tag})
        $display("FAIL case%0d data: got %h %h expected %h %h", i, walk_phys, walk_accesstag, got.phys, got.tag);
      else passes++;
      if (got.wr) begin
        checks++;
        if ({tlb_virtual_address_w, tlb_phys_w, tlb_accesstag_w} !== {got.va, got.phys, got.tag})
          $display("FAIL case%0d tlb: got %h %h %h expected %h %h %h", i, tlb_virtual_address_w, tlb_phys_w,
                   tlb_accesstag_w, got.va, got.phys, got.tag);
        else passes++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({req_rises - r0, wr_cnt - w0} !== {int'(c.n), int'(got.wr)})
        $display("FAIL case%0d counts: got reqs=%0d writes=%0d expected %0d/%0d", i, req_rises - r0, wr_cnt - w0, c.n, got.wr);
      else passes++;
    end
  endtask

  // second walk is requested in the IDLE cycle right after walk_done
  task automatic test_back_to_back();
    logic [33:0] a0, a1;
    bit stable, tmo, tmo2;
    int wait0, lat;
    exp_t e, got;
    e = make_exp(1'b0, 1'b0, 1'b1, 22'h000745, 8'h0F, 20'h12345);
    exp_q.push_back(e);
    last_phys = e.phys; last_tag = e.tag;
    drive_walk(22'h00080, 20'h12345, 1, 32'h0010000F, 32'h0, 1'b0, 0, 1'b0, a0, a1, stable, wait0, tmo);
    wait_done(lat, tmo2);
    got = exp_q.pop_front();
    checks++;
    if ({tmo2, walk_phys} !== {1'b0, got.phys}) $display("FAIL b2b_first: got %h expected %h", walk_phys, got.phys); else passes++;
    e = make_exp(1'b0, 1'b0, 1'b1, 22'h3ABCD, 8'hCB, 20'h00403);
    exp_q.push_back(e);
    last_phys = e.phys; last_tag = e.tag;
    drive_walk(22'h00100, 20'h00403, 2, 32'h00040001, 32'h0EAF34CB, 1'b0, 1, 1'b0, a0, a1, stable, wait0, tmo);
    wait_done(lat, tmo2);
    got = exp_q.pop_front();
    checks++;
    if ({wait0, a0, a1} !== {32'd0, 34'h100004, 34'h10000C})
      $display("FAIL b2b_second_addr: got wait=%0d %h/%h expected 0 100004/10000c", wait0, a0, a1); else passes++;
    checks++;
    if ({tmo2, tlb_command, tlb_virtual_address_w, walk_phys, walk_accesstag} !== {1'b0, CMD_WRITE, got.va, got.phys, got.tag})
      $display("FAIL b2b_second_result: got cmd=%b va=%h phys=%h tag=%h expected %b %h %h %h", tlb_command,
               tlb_virtual_address_w, walk_phys, walk_accesstag, CMD_WRITE, got.va, got.phys, got.tag);
    else passes++;
  endtask

  task automatic test_reset_midwalk();
    logic [33:0] a0, a1;
    bit stable, tmo, tmo2;
    int wait0, lat, w;
    exp_t e, got;
    e = make_exp(1'b0, 1'b0, 1'b1, 22'h000745, 8'h0F, 20'h12345);
    exp_q.push_back(e);
    drive_walk(22'h00080, 20'h12345, 1, 32'h0010000F, 32'h0, 1'b0, 0, 1'b0, a0, a1, stable, wait0, tmo);
    wait_done(lat, tmo2);
    got = exp_q.pop_front();
    checks++;
    if ({tmo2, tlb_command} !== {1'b0, CMD_WRITE}) $display("FAIL pre_reset_cmd: got %b expected %b", tlb_command, CMD_WRITE); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tlb_command, walk_done, walk_busy} !== {CMD_NONE, 1'b0, 1'b0})
      $display("FAIL reset_clears_cmd: got cmd=%b done=%0d busy=%0d expected 00/0/0", tlb_command, walk_done, walk_busy);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    last_phys = '0; last_tag = '0;
    @(negedge clk);
    satp_ppn = 22'h00080; walk_virtual_address = 20'h12345; walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    w = 0;
    while (mem_req !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if ({mem_req, walk_busy} !== 2'b11) $display("FAIL midwalk_req: got req=%0d busy=%0d expected 1/1", mem_req, walk_busy); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, walk_busy, tlb_command} !== {1'b0, 1'b0, CMD_NONE})
      $display("FAIL midwalk_reset: got req=%0d busy=%0d cmd=%b expected 0/0/00", mem_req, walk_busy, tlb_command);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    e = make_exp(1'b0, 1'b0, 1'b1, 22'h012345, 8'hCF, 20'h12345);
    exp_q.push_back(e);
    last_phys = e.phys; last_tag = e.tag;
    drive_walk(22'h00080, 20'h12345, 2, 32'h00020401, 32'h048D14CF, 1'b0, 0, 1'b0, a0, a1, stable, wait0, tmo);
    wait_done(lat, tmo2);
    got = exp_q.pop_front();
    checks++;
    if ({tmo, tmo2, a0, a1} !== {1'b0, 1'b0, 34'h80120, 34'h81D14})
      $display("FAIL after_reset_addr: got %h/%h expected 80120/81d14", a0, a1); else passes++;
    checks++;
    if ({walk_pagefault, walk_accessfault, tlb_command, walk_phys, walk_accesstag} !== {got.pf, got.af, CMD_WRITE, got.phys, got.tag})
      $display("FAIL after_reset_result: got pf=%0d af=%0d cmd=%b phys=%h tag=%h expected %0d %0d %b %h %h",
               walk_pagefault, walk_accessfault, tlb_command, walk_phys, walk_accesstag,
               got.pf, got.af, CMD_WRITE, got.phys, got.tag);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_two_level("two_level", 0, 1'b0);
    test_leaf_cases();
    test_two_level("delayed_ack", 5, 1'b0);
    test_two_level("req_held_busy", 2, 1'b1);
    test_back_to_back();
    test_reset_midwalk();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
